// File: rtl/gate_bist_checker.sv
// Built-in self-test controller for the NAND-built basic gate unit.
// Sweeps {a,b} through 00,01,10,11 for LOOPS passes. Each vector settles for
// SETTLE_CYCLES cycles and is then checked for one cycle against golden
// values. The controller counts mismatching vectors, saturating the count,
// and records the first failing vector together with its mismatch bits.
module gate_bist_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  input  logic             xor_in,
  input  logic             xnor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [4:0]       fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [7:0]       loop_q, loop_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             first_fail_q, first_fail_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic [4:0]       fail_mask_q, fail_mask_d;

  logic [4:0]       golden;
  logic [4:0]       mismatch;
  logic             any_mismatch;
  logic [ERR_W-1:0] err_next;
  logic             last_vector;

  // Golden responses for the vector currently driven, and the per-bit mismatches.
  always_comb begin
    golden       = {vec_q[1] & vec_q[0],
                    vec_q[1] | vec_q[0],
                    ~vec_q[1],
                    vec_q[1] ^ vec_q[0],
                    ~(vec_q[1] ^ vec_q[0])};
    mismatch     = golden ^ {and_in, or_in, not_in, xor_in, xnor_in};
    any_mismatch = |mismatch;
    err_next     = err_q;
    if (any_mismatch && (err_q != ERR_MAX)) begin
      err_next = err_q + 1'b1;
    end
    last_vector  = (vec_q == 2'b11) && (loop_q == LOOP_LAST);
  end

  // Next-state and datapath updates for the sweep controller.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    loop_d       = loop_q;
    settle_d     = settle_q;
    err_d        = err_q;
    pass_d       = pass_q;
    first_fail_d = first_fail_q;
    fail_vec_d   = fail_vec_q;
    fail_mask_d  = fail_mask_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SETTLE;
          vec_d        = 2'b00;
          loop_d       = '0;
          settle_d     = '0;
          err_d        = '0;
          pass_d       = 1'b0;
          first_fail_d = 1'b0;
          fail_vec_d   = '0;
          fail_mask_d  = '0;
        end
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_CHECK: begin
        settle_d = '0;
        err_d    = err_next;
        if (any_mismatch && !first_fail_q) begin
          first_fail_d = 1'b1;
          fail_vec_d   = vec_q;
          fail_mask_d  = mismatch;
        end
        if (last_vector) begin
          state_d = S_DONE;
          vec_d   = 2'b00;
          pass_d  = (err_next == '0);
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 1'b1;
          if (vec_q == 2'b11) begin
            loop_d = loop_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= 2'b00;
      loop_q       <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      first_fail_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      loop_q       <= loop_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      first_fail_q <= first_fail_d;
      fail_vec_q   <= fail_vec_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

  // busy and done decode straight from the registered state, so they are glitch-free.
  always_comb begin
    a         = vec_q[1];
    b         = vec_q[0];
    busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    err_count = err_q;
    fail_vec  = fail_vec_q;
    fail_mask = fail_mask_q;
  end

endmodule
